// File: rtl/ibram_pkg.sv
// Shared types and width helpers for the ping-pong input-activation buffer.
package ibram_pkg;

  // Write-ownership state of the buffer; encoding is visible on the mode port.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    INIT_WRITE = 2'd1,
    WRITE      = 2'd2
  } ibram_state_e;

  // Narrow read words packed into one wide write word.
  function automatic int ibram_ratio(input int write_width, input int read_width);
    return write_width / read_width;
  endfunction

  // Narrow-word address width within one half-buffer.
  function automatic int ibram_addr_w(input int write_depth, input int ratio);
    return $clog2(write_depth * ratio);
  endfunction

  // Width able to hold a fill count from 0 up to and including write_depth.
  function automatic int ibram_len_w(input int write_depth);
    return $clog2(write_depth) + 1;
  endfunction

endpackage

// File: rtl/ibram_bank.sv
// One double-buffered asymmetric RAM: wide write port, narrow registered read.
// The address MSB selects the half; lane 0 of a read is the write word's LSBs.
// RATIO is expected to be a power of two of at least 2.
module ibram_bank
  import ibram_pkg::*;
#(
  parameter int  WRITE_WIDTH = 128,
  parameter int  WRITE_DEPTH = 128,
  parameter int  READ_WIDTH  = 8,
  localparam int RATIO       = ibram_ratio(WRITE_WIDTH, READ_WIDTH),
  localparam int LANE_W      = $clog2(RATIO),
  localparam int WAW         = $clog2(2 * WRITE_DEPTH),
  localparam int RAW         = WAW + LANE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [WAW-1:0]         waddr,
  input  logic [WRITE_WIDTH-1:0] wdata,
  input  logic                   re,
  input  logic                   rclr,
  input  logic [RAW-1:0]         raddr,
  output logic [READ_WIDTH-1:0]  rdata
);

  logic [WRITE_WIDTH-1:0] mem [2*WRITE_DEPTH];
  logic [READ_WIDTH-1:0]  rdata_q;

  // Wide write port; contents are never reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Narrow registered read; the output register alone is reset, holds between
  // reads, and is zeroed by rclr when the top rejects an out-of-range read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rclr) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr[RAW-1:LANE_W]][raddr[LANE_W-1:0]*READ_WIDTH +: READ_WIDTH];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ibram_pingpong_buffer.sv
// Ping-pong input-activation buffer: NUM_BANKS banks, each with two halves that
// are filled by a writer, committed, read, and released back to the writer.
// Port 1 broadcasts to a bank mask (INIT_WRITE), port 2 writes per bank (WRITE).
// Optional feature: define IBRAM_BOUNDS_CHECK_EN to reject reads beyond the
// committed length (zero data plus an rd_oob strobe).
module ibram_pingpong_buffer
  import ibram_pkg::*;
#(
  parameter int  NUM_BANKS   = 16,
  parameter int  WRITE_WIDTH = 128,
  parameter int  WRITE_DEPTH = 128,
  parameter int  READ_WIDTH  = 8,
  localparam int RATIO       = ibram_ratio(WRITE_WIDTH, READ_WIDTH),
  localparam int READ_DEPTH  = WRITE_DEPTH * RATIO,
  localparam int AW          = ibram_addr_w(WRITE_DEPTH, RATIO),
  localparam int LW          = ibram_len_w(WRITE_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr1_valid,
  output logic                            wr1_ready,
  input  logic [WRITE_WIDTH-1:0]          wr1_data,
  input  logic [NUM_BANKS-1:0]            wr1_bank_mask,
  input  logic                            wr1_last,
  input  logic [NUM_BANKS-1:0]            wr2_valid,
  output logic [NUM_BANKS-1:0]            wr2_ready,
  input  logic [NUM_BANKS*WRITE_WIDTH-1:0] wr2_data,
  input  logic [NUM_BANKS-1:0]            wr2_last,
  input  logic [NUM_BANKS-1:0]            rd_en,
  input  logic [NUM_BANKS*AW-1:0]         rd_addr,
  output logic [NUM_BANKS*READ_WIDTH-1:0] rd_data,
  output logic [NUM_BANKS-1:0]            rd_data_valid,
  input  logic [NUM_BANKS-1:0]            rd_release,
  output logic [NUM_BANKS-1:0]            buf_ready,
  output logic [NUM_BANKS*LW-1:0]         buf_len,
  output logic [NUM_BANKS-1:0]            rd_oob,
  output logic [1:0]                      mode
);

  localparam logic [LW-1:0] DEPTH_CNT = LW'(WRITE_DEPTH);

  ibram_state_e         state_q, state_d;
  logic [NUM_BANKS-1:0] writable;
  logic [NUM_BANKS-1:0] done_vec;
  logic [NUM_BANKS-1:0] wr2_fire;
  logic                 wr1_fire;
  logic                 wr1_last_fire;
  logic                 all_done;

  // Readies look only at registered state (plus the beat's mask for port 1).
  // A zero mask leaves every bank unconstrained, so the beat is accepted and dropped.
  assign wr1_ready     = (state_q == INIT_WRITE) && (&(writable | ~wr1_bank_mask));
  assign wr2_ready     = {NUM_BANKS{state_q == WRITE}} & writable & ~done_vec;
  assign wr1_fire      = wr1_valid && wr1_ready;
  assign wr1_last_fire = wr1_fire && wr1_last;
  assign wr2_fire      = wr2_valid & wr2_ready;
  // Every bank has delivered its final beat, counting beats landing this cycle.
  assign all_done      = &(done_vec | (wr2_fire & wr2_last));
  assign mode          = state_q;

  // Next write owner: port 1 takes priority when both writers request together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr1_valid) begin
          state_d = INIT_WRITE;
        end else if (|wr2_valid) begin
          state_d = WRITE;
        end
      end
      INIT_WRITE: begin
        if (wr1_last_fire) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (all_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-ownership FSM register; mode is driven straight from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [1:0]             full_q, full_d;
    logic [1:0][LW-1:0]     len_q, len_d;
    logic [LW-1:0]          wcnt_q, wcnt_d;
    logic                   wsel_q, wsel_d;
    logic                   rsel_q, rsel_d;
    logic                   touched_q, touched_d;
    logic                   done_q, done_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [LW-1:0]          wcnt_inc;
    logic                   bank_we;
    logic                   bank_commit;
    logic                   bank_release;
    logic                   rd_ok;
    logic                   rd_oob_w;
    logic [WRITE_WIDTH-1:0] bank_wdata;

    assign wcnt_inc      = wcnt_q + 1'b1;
    assign writable[gi]  = !full_q[wsel_q] && (wcnt_q < DEPTH_CNT);
    assign done_vec[gi]  = done_q;
    assign bank_we       = (wr1_fire && wr1_bank_mask[gi]) || wr2_fire[gi];
    assign bank_wdata    = (state_q == INIT_WRITE) ? wr1_data
                                                   : wr2_data[gi*WRITE_WIDTH +: WRITE_WIDTH];
    // Commit on a beat that fills the half, on this bank's final beat, or when
    // a broadcast session ends after having written this bank earlier.
    assign bank_commit   = (bank_we && ((wcnt_inc == DEPTH_CNT) || wr1_last_fire ||
                                        (wr2_fire[gi] && wr2_last[gi]))) ||
                           (wr1_last_fire && touched_q);
    assign bank_release  = rd_release[gi] && full_q[rsel_q];
    assign rd_ok         = rd_en[gi] && full_q[rsel_q];

    assign buf_ready[gi]             = full_q[rsel_q];
    assign buf_len[gi*LW +: LW]      = len_q[rsel_q];
    assign rd_data_valid[gi]         = rd_valid_q;

`ifdef IBRAM_BOUNDS_CHECK_EN
    logic          rd_oob_q, rd_oob_d;
    logic [AW+1:0] rd_limit;

    assign rd_limit = (AW+2)'(len_q[rsel_q]) * (AW+2)'(RATIO);
    assign rd_oob_w = rd_ok && ((AW+2)'(rd_addr[gi*AW +: AW]) >= rd_limit);

    // Out-of-range strobe lines up with the read data it flags.
    always_comb begin
      rd_oob_d = rd_oob_w;
    end

    // Out-of-range strobe register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_oob_q <= 1'b0;
      end else begin
        rd_oob_q <= rd_oob_d;
      end
    end

    assign rd_oob[gi] = rd_oob_q;
`else
    assign rd_oob_w   = 1'b0;
    assign rd_oob[gi] = 1'b0;
`endif

    // Per-bank bookkeeping: fill count, commit/release of halves, session flags.
    // Commit targets half wsel (needs !full) and release targets half rsel
    // (needs full), so the two never collide on the same half.
    always_comb begin
      full_d     = full_q;
      len_d      = len_q;
      wcnt_d     = wcnt_q;
      wsel_d     = wsel_q;
      rsel_d     = rsel_q;
      touched_d  = touched_q;
      done_d     = done_q;
      rd_valid_d = rd_ok;
      if (bank_we) begin
        wcnt_d = wcnt_inc;
        if (state_q == INIT_WRITE) begin
          touched_d = 1'b1;
        end
      end
      if (bank_commit) begin
        full_d[wsel_q] = 1'b1;
        len_d[wsel_q]  = bank_we ? wcnt_inc : wcnt_q;
        wsel_d         = ~wsel_q;
        wcnt_d         = '0;
        touched_d      = 1'b0;
      end
      if (bank_release) begin
        full_d[rsel_q] = 1'b0;
        rsel_d         = ~rsel_q;
      end
      if (state_q == WRITE) begin
        if (all_done) begin
          done_d = 1'b0;
        end else if (wr2_fire[gi] && wr2_last[gi]) begin
          done_d = 1'b1;
        end
      end
    end

    // Per-bank state registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        full_q     <= '0;
        len_q      <= '0;
        wcnt_q     <= '0;
        wsel_q     <= 1'b0;
        rsel_q     <= 1'b0;
        touched_q  <= 1'b0;
        done_q     <= 1'b0;
        rd_valid_q <= 1'b0;
      end else begin
        full_q     <= full_d;
        len_q      <= len_d;
        wcnt_q     <= wcnt_d;
        wsel_q     <= wsel_d;
        rsel_q     <= rsel_d;
        touched_q  <= touched_d;
        done_q     <= done_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    ibram_bank #(
      .WRITE_WIDTH (WRITE_WIDTH),
      .WRITE_DEPTH (WRITE_DEPTH),
      .READ_WIDTH  (READ_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we),
      .waddr ({wsel_q, wcnt_q[LW-2:0]}),
      .wdata (bank_wdata),
      .re    (rd_ok && !rd_oob_w),
      .rclr  (rd_oob_w),
      .raddr ({rsel_q, rd_addr[gi*AW +: AW]}),
      .rdata (rd_data[gi*READ_WIDTH +: READ_WIDTH])
    );
  end

endmodule
